// File: rtl/if_prefetch_queue_if.sv
// Bundles the fetch-request, fetch-response, redirect and IF/ID-side signals of
// the instruction prefetch queue. "master" is the prefetch queue itself, "slave"
// is the surrounding environment (instruction memory, EX/MEM, IF/ID).
//
// Handshake rule used on every valid/ready pair here: a transfer happens in
// exactly the cycle where valid and ready are both high at the rising clock edge.
// Ready may depend on valid. The imem response channel has no ready: a word
// presented with imem_rsp_valid is always taken.
interface if_prefetch_queue_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic [31:0] out_instr;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output out_valid, out_pc, out_pc_plus4, out_instr,
    input  out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  out_valid, out_pc, out_pc_plus4, out_instr,
    output out_ready
  );
endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch prefetch queue. Issues in-order fetches under a credit limit
// (FIFO occupancy + in-flight <= DEPTH), buffers returned words with their PC,
// and presents {pc, pc+4, instr} to IF/ID. A redirect flushes the FIFO, retargets
// fetch and marks every still-outstanding response for discard.
module if_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  if_prefetch_queue_if.master      bus,
  output logic [$clog2(DEPTH):0]   dbg_count_o,
  output logic [$clog2(DEPTH):0]   dbg_inflight_o,
  output logic [$clog2(DEPTH):0]   dbg_discard_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];

  logic [CW:0]   occupancy;
  logic          req_fire;
  logic          push;
  logic          pop;
  logic [31:0]   redirect_aligned;

  // Handshake outputs, credit check and next-state for all counters and pointers.
  always_comb begin
    occupancy        = {1'b0, count_q} + {1'b0, inflight_q};
    redirect_aligned = {bus.redirect_pc[31:2], 2'b00};

    bus.imem_req_valid = rst_n & ~bus.redirect_valid & (occupancy < (CW+1)'(DEPTH));
    bus.imem_req_addr  = fetch_pc_q;
    bus.out_valid      = rst_n & (count_q != '0) & ~bus.redirect_valid;
    bus.out_pc         = pc_mem_q[rd_ptr_q];
    bus.out_pc_plus4   = pc_mem_q[rd_ptr_q] + 32'd4;
    bus.out_instr      = instr_mem_q[rd_ptr_q];

    req_fire = bus.imem_req_valid & bus.imem_req_ready;
    pop      = bus.out_valid & bus.out_ready;
    // A response is kept only if it is not owed to an earlier redirect and is
    // not itself cancelled by a redirect in the same cycle.
    push     = rst_n & bus.imem_rsp_valid & (discard_q == '0) & ~bus.redirect_valid;

    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    discard_d  = discard_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(bus.imem_rsp_valid);

    if (push) begin
      rsp_pc_d = rsp_pc_q + 32'd4;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    if (bus.redirect_valid) begin
      // Everything still outstanding after this cycle's response belongs to the
      // old path; inflight already includes any earlier discards.
      fetch_pc_d = redirect_aligned;
      rsp_pc_d   = redirect_aligned;
      discard_d  = inflight_q - CW'(bus.imem_rsp_valid);
      count_d    = '0;
      rd_ptr_d   = wr_ptr_q;
    end else begin
      if (bus.imem_rsp_valid && discard_q != '0) begin
        discard_d = discard_q - CW'(1);
      end
      count_d  = count_q + CW'(push) - CW'(pop);
      rd_ptr_d = rd_ptr_q + PW'(pop);
    end

    dbg_count_o    = count_q;
    dbg_inflight_o = inflight_q;
    dbg_discard_o  = discard_q;
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // FIFO storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= rsp_pc_q;
      instr_mem_q[wr_ptr_q] <= bus.imem_rsp_data;
    end
  end

  // The credit limit makes a push into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && count_q == CW'(DEPTH)));
endmodule

// File: tb/tb_if_prefetch_queue.sv
// Randomized bench for if_prefetch_queue. The reference model views the design
// as a stream: every redirect/reset starts a new epoch at a target PC; only
// responses to requests issued in the current epoch reach the output queue.
module tb_if_prefetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] due;
    logic [31:0] addr;
    logic [31:0] epoch;
  } mem_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] dbg_count, dbg_inflight, dbg_discard;

  if_prefetch_queue_if bus();

  if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .dbg_count_o    (dbg_count),
    .dbg_inflight_o (dbg_inflight),
    .dbg_discard_o  (dbg_discard)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          last_due = 0;
  logic [31:0] exp_fetch = RESET_PC;
  logic [31:0] exp_rsp_pc = RESET_PC;
  logic [63:0] exp_q[$];
  mem_t        mem_q[$];
  logic        prev_redir = 1'b0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // first_act: 0 none, 1 redirect to 0xFFFFFFFC in first cycle, 2 reset in first cycle.
  task automatic run_phase(input int n, input int lat, input int rdy_pct, input int ordy_pct,
                           input int redir_pct, input int rst_pct, input int first_act);
    logic        rsp_now, redir, exp_rv, exp_ov, dut_acc, mdl_acc, pop, keep;
    logic [31:0] tgt;
    mem_t        e;
    int          due;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n = !(($urandom_range(0, 99) < rst_pct) || (i == 0 && first_act == 2));
      bus.imem_req_ready = ($urandom_range(0, 99) < rdy_pct);
      bus.out_ready      = ($urandom_range(0, 99) < ordy_pct);
      redir = rst_n && !prev_redir &&
              (($urandom_range(0, 99) < redir_pct) || (i == 0 && first_act == 1));
      case ($urandom_range(0, 3))
        0:       tgt = 32'hFFFF_FFFC;
        1:       tgt = $urandom();
        2:       tgt = 32'h0000_0100;
        default: tgt = 32'($urandom_range(0, 1023)) << 2;
      endcase
      if (i == 0 && first_act == 1) tgt = 32'hFFFF_FFFC;
      bus.redirect_valid = redir;
      bus.redirect_pc    = tgt;
      rsp_now = rst_n && (mem_q.size() > 0) && (mem_q[0].due == 32'(cyc));
      bus.imem_rsp_valid = rsp_now;
      bus.imem_rsp_data  = rsp_now ? instr_of(mem_q[0].addr) : $urandom();
      #1;
      // Expected outputs from the stream model.
      exp_rv = rst_n && !redir && (exp_q.size() + mem_q.size() < DEPTH);
      exp_ov = rst_n && !redir && (exp_q.size() != 0);
      check_eq("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
      if (exp_rv) check_eq("req_addr", bus.imem_req_addr, exp_fetch);
      check_eq("out_valid", 32'(bus.out_valid), 32'(exp_ov));
      if (exp_ov) begin
        check_eq("out_pc", bus.out_pc, exp_q[0][63:32]);
        check_eq("out_pc_plus4", bus.out_pc_plus4, exp_q[0][63:32] + 32'd4);
        check_eq("out_instr", bus.out_instr, exp_q[0][31:0]);
      end
      if (rst_n) begin
        int stale = 0;
        foreach (mem_q[k]) if (mem_q[k].epoch != 32'(epoch)) stale++;
        check_eq("count", 32'(dbg_count), 32'(exp_q.size()));
        check_eq("inflight", 32'(dbg_inflight), 32'(mem_q.size()));
        check_eq("discard", 32'(dbg_discard), 32'(stale));
      end
      // Advance the model and the memory across the coming edge.
      dut_acc = bus.imem_req_valid && bus.imem_req_ready;
      mdl_acc = exp_rv && bus.imem_req_ready;
      pop     = exp_ov && bus.out_ready;
      if (!rst_n) begin
        mem_q.delete();
        exp_q.delete();
        exp_fetch  = RESET_PC;
        exp_rsp_pc = RESET_PC;
        epoch++;
      end else begin
        keep = 1'b0;
        if (rsp_now) begin
          e    = mem_q.pop_front();
          keep = (e.epoch == 32'(epoch)) && !redir;
        end
        if (dut_acc) begin
          due = cyc + lat;
          if (due <= last_due) due = last_due + 1;
          mem_q.push_back({32'(due), bus.imem_req_addr, 32'(epoch)});
          last_due = due;
        end
        if (mdl_acc) exp_fetch = exp_fetch + 32'd4;
        if (redir) begin
          epoch++;
          exp_q.delete();
          exp_fetch  = {tgt[31:2], 2'b00};
          exp_rsp_pc = {tgt[31:2], 2'b00};
        end else begin
          if (pop) void'(exp_q.pop_front());
          if (keep) begin
            exp_q.push_back({exp_rsp_pc, instr_of(exp_rsp_pc)});
            exp_rsp_pc = exp_rsp_pc + 32'd4;
          end
        end
      end
      prev_redir = redir;
      @(posedge clk);
      cyc++;
    end
  endtask

  // ---------------- stimulus sequence and report ----------------
  initial begin
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b0;
    run_phase(3,   1, 100, 100, 0, 100, 0);  // reset
    run_phase(30,  1, 100, 100, 0, 0,   0);  // streaming, 1-cycle memory
    run_phase(20,  1, 100, 0,   0, 0,   0);  // IF/ID stall fills credit
    run_phase(20,  1, 100, 100, 0, 0,   0);  // drain
    run_phase(40,  3, 100, 100, 0, 0,   1);  // redirect to top of address space
    run_phase(80,  3, 100, 100, 12, 0,  0);  // redirects with outstanding fetches
    run_phase(10,  2, 100, 100, 0, 0,   2);  // reset mid-stream
    run_phase(300, 2, 60,  60,  8, 0,   0);  // random handshakes
    run_phase(300, 3, 50,  70,  6, 2,   0);  // random with occasional reset
    run_phase(200, 1, 80,  40,  10, 0,  0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
